// File: rtl/dram_pkg.sv
// dram_pkg
//   Shared definitions for the DRAM link between the cache arbiter, the caches
//   and the memory-side endpoint (dram_slave_model).
//   Contents: command encodings, default bus widths, request/response records.
package dram_pkg;

  localparam int DRAM_ADDR_W = 32;
  localparam int DRAM_DATA_W = 32;

  localparam logic CMD_READ  = 1'b1;
  localparam logic CMD_WRITE = 1'b0;

  typedef struct packed {
    logic                   cmd;
    logic [DRAM_ADDR_W-1:0] addr;
    logic [DRAM_DATA_W-1:0] data;
  } dram_req_t;

  typedef struct packed {
    logic [DRAM_DATA_W-1:0] data;
  } dram_rsp_t;

endpackage

// File: rtl/dram_slave_model_if.sv
// dram_slave_model_if
//   DRAM link bundle: request channel (req_en/req_rdy/req_cmd/req_addr/req_data)
//   and response channel (rsp_en/rsp_rdy/rsp_data).
//   master modport: the requester (cache arbiter or testbench).
//   slave  modport: the memory endpoint.
interface dram_slave_model_if
  import dram_pkg::*;
#(
  parameter int ADDR_W = DRAM_ADDR_W,
  parameter int DATA_W = DRAM_DATA_W
) ();

  logic              req_en;
  logic              req_rdy;
  logic              req_cmd;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;
  logic              rsp_en;
  logic              rsp_rdy;
  logic [DATA_W-1:0] rsp_data;

  modport master (
    output req_en, req_cmd, req_addr, req_data, rsp_rdy,
    input  req_rdy, rsp_en, rsp_data
  );

  modport slave (
    input  req_en, req_cmd, req_addr, req_data, rsp_rdy,
    output req_rdy, rsp_en, rsp_data
  );

endinterface

// File: rtl/sync_fifo.sv
// sync_fifo
//   Generic single-clock FIFO with a registered head output.
//   Ports: clk, rstn (async active-low), i_push/i_push_data (write side),
//          i_pop (ignored when empty), o_empty, o_full,
//          o_head (registered head word, 0 while empty).
//   Pointers carry an extra lap bit so full/empty are told apart by it.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_empty,
  output logic             o_full,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [AW:0]      w_wr_ptr_next;
  logic [AW:0]      w_rd_ptr_next;
  logic             w_pop_ok;
  logic [WIDTH-1:0] r_head;
  logic [WIDTH-1:0] w_head_next;
  logic [WIDTH-1:0] r_mem [0:DEPTH-1];

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign o_head  = r_head;

  assign w_pop_ok      = i_pop && !o_empty;
  assign w_rd_ptr_next = r_rd_ptr + (AW+1)'(w_pop_ok);
  assign w_wr_ptr_next = r_wr_ptr + (AW+1)'(i_push);

  // Head register is computed from next-state pointers so it is valid in the
  // same cycle the pointers move. If the next head slot is the one being
  // written right now, take the incoming word instead of stale storage.
  always_comb begin
    w_head_next = '0;
    if (w_rd_ptr_next != w_wr_ptr_next) begin
      if (i_push && (w_rd_ptr_next[AW-1:0] == r_wr_ptr[AW-1:0]))
        w_head_next = i_push_data;
      else
        w_head_next = r_mem[w_rd_ptr_next[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_head   <= '0;
    end else begin
      r_wr_ptr <= w_wr_ptr_next;
      r_rd_ptr <= w_rd_ptr_next;
      r_head   <= w_head_next;
    end
  end

endmodule

// File: rtl/dram_slave_model.sv
// dram_slave_model
//   Memory-side endpoint of the cache arbiter's DRAM link. Writes are posted
//   into a word-addressed RAM; reads sample the RAM, travel a fixed READ_LAT
//   pipe and queue in a response FIFO, returning strictly in request order.
//   Ports: clk, rstn (async active-low), bus (dram_slave_model_if.slave).
//   A credit counter (reads in pipe + FIFO occupancy) throttles req_rdy so the
//   pipe can always drain into the FIFO.
module dram_slave_model
  import dram_pkg::*;
#(
  parameter int ADDR_W    = DRAM_ADDR_W,
  parameter int DATA_W    = DRAM_DATA_W,
  parameter int MEM_AW    = 14,
  parameter int READ_LAT  = 4,
  parameter int RSP_DEPTH = 8
) (
  input logic               clk,
  input logic               rstn,
  dram_slave_model_if.slave bus
);

  localparam int CNT_W = $clog2(RSP_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  if (READ_LAT < 1 || READ_LAT > 16) begin : g_bad_read_lat
    $error("dram_slave_model: READ_LAT must be within 1..16");
  end

  logic              r_run;
  logic [CNT_W-1:0]  r_outstanding;
  logic              w_req_rdy;
  logic              w_hs;
  logic              w_rd_hs;
  logic              w_wr_hs;
  logic              w_pop;
  logic              w_fifo_empty;
  logic              w_fifo_full;
  logic [DATA_W-1:0] w_rsp_data;
  logic [MEM_AW-1:0] w_idx;
  logic              w_unused_addr;

  logic [DATA_W-1:0]   r_mem [0:(2**MEM_AW)-1];
  logic [READ_LAT-1:0] r_pipe_vld;
  logic [DATA_W-1:0]   r_pipe_data [0:READ_LAT-1];

  assign w_idx         = bus.req_addr[MEM_AW+1:2];
  assign w_unused_addr = ^{bus.req_addr[ADDR_W-1:MEM_AW+2], bus.req_addr[1:0]};

  // r_run keeps req_rdy low through reset and rises on the first edge after.
  assign w_req_rdy = r_run && (r_outstanding < DEPTH_C);
  assign w_hs      = bus.req_en && w_req_rdy;
  assign w_rd_hs   = w_hs && (bus.req_cmd == CMD_READ);
  assign w_wr_hs   = w_hs && (bus.req_cmd == CMD_WRITE);
  assign w_pop     = bus.rsp_rdy && !w_fifo_empty;

  assign bus.req_rdy  = w_req_rdy;
  assign bus.rsp_en   = !w_fifo_empty;
  assign bus.rsp_data = w_rsp_data;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_run         <= 1'b0;
      r_outstanding <= '0;
    end else begin
      r_run <= 1'b1;
      case ({w_rd_hs, w_pop})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // RAM with registered read feeding pipe stage 0. The data pipe carries no
  // reset; only the valid bits decide whether a word reaches the FIFO.
  always_ff @(posedge clk) begin
    if (w_wr_hs) r_mem[w_idx] <= bus.req_data;
    r_pipe_data[0] <= r_mem[w_idx];
    for (int i = 1; i < READ_LAT; i++) r_pipe_data[i] <= r_pipe_data[i-1];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld[0] <= w_rd_hs;
      for (int i = 1; i < READ_LAT; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
    end
  end

  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .i_push      (r_pipe_vld[READ_LAT-1]),
    .i_push_data (r_pipe_data[READ_LAT-1]),
    .i_pop       (w_pop),
    .o_empty     (w_fifo_empty),
    .o_full      (w_fifo_full),
    .o_head      (w_rsp_data)
  );

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rstn) begin
      assert (!(r_pipe_vld[READ_LAT-1] && w_fifo_full && !w_pop))
        else $error("dram_slave_model: response FIFO push while full");
      assert (r_outstanding <= DEPTH_C)
        else $error("dram_slave_model: outstanding reads exceed RSP_DEPTH");
    end
  end
`endif

endmodule

// File: tb/tb_dram_slave_model.sv
module tb_dram_slave_model;
  import dram_pkg::*;

  localparam int READ_LAT  = 4;
  localparam int RSP_DEPTH = 8;
  localparam int MEM_AW    = 14;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  dram_slave_model_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dram_slave_model #(
    .ADDR_W(32), .DATA_W(32), .MEM_AW(MEM_AW),
    .READ_LAT(READ_LAT), .RSP_DEPTH(RSP_DEPTH)
  ) u_dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  // ---------------- reference model: queues and an address map ----------
  typedef struct { logic [31:0] d; int due; } pe_t;
  typedef struct { logic cmd; logic [31:0] addr; logic [31:0] wdata; logic [31:0] exp; } vec_t;

  logic [31:0] m_mem [int];
  pe_t         m_pipe [$];
  logic [31:0] m_fifo [$];
  bit          m_run = 0;
  int          cyc = 0;

  logic [31:0] got [$];
  logic [31:0] exp_q [$];
  vec_t        tq [$];
  bit          last_acc;
  int          n_pass = 0;
  int          n_total = 0;

  function automatic int widx(logic [31:0] a);
    return int'(a[MEM_AW+1:2]);
  endfunction

  function automatic logic [31:0] m_head();
    return (m_fifo.size() > 0) ? m_fifo[0] : 32'h0;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // One clock: check outputs, drive, advance the model across the edge.
  // Called at a negedge, returns at the next negedge.
  task automatic step(input logic en, input logic cmd, input logic [31:0] addr,
                      input logic [31:0] data, input logic rdy);
    bit  exp_rdy;
    bit  hs;
    pe_t p;
    exp_rdy = m_run && ((m_pipe.size() + m_fifo.size()) < RSP_DEPTH);
    chk("req_rdy", 32'(bus.req_rdy), 32'(exp_rdy));
    chk("rsp_en", 32'(bus.rsp_en), 32'(m_fifo.size() > 0));
    chk("rsp_data", bus.rsp_data, m_head());
    bus.req_en   = en;
    bus.req_cmd  = cmd;
    bus.req_addr = addr;
    bus.req_data = data;
    bus.rsp_rdy  = rdy;
    last_acc = en && bus.req_rdy;
    if (last_acc)
      $display("req  cyc=%0d %s addr=%h data=%h", cyc, cmd ? "RD" : "WR", addr, data);
    if (bus.rsp_en && rdy) begin
      got.push_back(bus.rsp_data);
      $display("rsp  cyc=%0d data=%h", cyc, bus.rsp_data);
    end
    @(posedge clk);
    hs = en && exp_rdy;
    if (rdy && m_fifo.size() > 0) void'(m_fifo.pop_front());
    while (m_pipe.size() > 0 && m_pipe[0].due <= cyc) begin
      p = m_pipe.pop_front();
      m_fifo.push_back(p.d);
    end
    if (hs) begin
      if (cmd == CMD_READ) begin
        p.d   = m_mem.exists(widx(addr)) ? m_mem[widx(addr)] : 32'h0;
        p.due = cyc + READ_LAT;
        m_pipe.push_back(p);
      end else begin
        m_mem[widx(addr)] = data;
      end
    end
    m_run = 1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, CMD_READ, 32'h0, 32'h0, rdy);
  endtask

  task automatic drain(input string name, input int n_expect);
    int n;
    n = 0;
    while (got.size() < n_expect && n < 60) begin
      idle(1'b1);
      n++;
    end
    chk({name, "_count"}, 32'(got.size()), 32'(n_expect));
  endtask

  // Apply every record of tq back to back, then compare collected read data.
  task automatic run_table(input string name);
    got.delete();
    exp_q.delete();
    foreach (tq[i]) begin
      step(1'b1, tq[i].cmd, tq[i].addr, tq[i].wdata, 1'b1);
      chk($sformatf("%s_acc%0d", name, i), 32'(last_acc), 32'd1);
      if (tq[i].cmd == CMD_READ) exp_q.push_back(tq[i].exp);
    end
    drain(name, exp_q.size());
    foreach (exp_q[i])
      if (i < got.size()) chk($sformatf("%s_rsp%0d", name, i), got[i], exp_q[i]);
  endtask

  function automatic vec_t mk(logic cmd, logic [31:0] addr, logic [31:0] wd, logic [31:0] ex);
    vec_t v;
    v.cmd = cmd; v.addr = addr; v.wdata = wd; v.exp = ex;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int acc;
    bit rdy_ok;
    logic [31:0] a;

    bus.req_en = 0; bus.req_cmd = 0; bus.req_addr = 0; bus.req_data = 0; bus.rsp_rdy = 0;
    rstn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_rdy", 32'(bus.req_rdy), 32'd0);
    chk("reset_rsp_en", 32'(bus.rsp_en), 32'd0);
    chk("reset_rsp_data", bus.rsp_data, 32'h0);
    rstn = 1;
    idle(1'b0);   // req_rdy must still be low here; rises after this edge

    // preload a scratch region for random and wrap traffic
    for (int i = 0; i < 16; i++) step(1'b1, CMD_WRITE, 32'h1000 + 32'(4*i), $urandom, 1'b1);

    // 1: write then read, measure latency
    step(1'b1, CMD_WRITE, 32'h100, 32'hDEADBEEF, 1'b1);
    step(1'b1, CMD_READ, 32'h100, 32'h0, 1'b1);
    n = 0;
    while (!bus.rsp_en && n < 20) begin idle(1'b1); n++; end
    chk("t1_latency", 32'(n), 32'(READ_LAT));
    chk("t1_data", bus.rsp_data, 32'hDEADBEEF);
    idle(1'b1);

    // 2: preload and back-to-back reads
    tq.delete();
    tq.push_back(mk(CMD_WRITE, 32'h0, 32'd1, 32'h0));
    tq.push_back(mk(CMD_WRITE, 32'h4, 32'd2, 32'h0));
    tq.push_back(mk(CMD_WRITE, 32'h8, 32'd3, 32'h0));
    tq.push_back(mk(CMD_WRITE, 32'hC, 32'd4, 32'h0));
    tq.push_back(mk(CMD_READ,  32'h0, 32'h0, 32'd1));
    tq.push_back(mk(CMD_READ,  32'h4, 32'h0, 32'd2));
    tq.push_back(mk(CMD_READ,  32'h8, 32'h0, 32'd3));
    tq.push_back(mk(CMD_READ,  32'hC, 32'h0, 32'd4));
    run_table("t2");

    // 3: credit exhaustion with rsp_rdy low
    for (int i = 0; i < 10; i++) step(1'b1, CMD_WRITE, 32'h2000 + 32'(4*i), 32'h3000 + 32'(i), 1'b1);
    got.delete();
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, CMD_READ, 32'h2000 + 32'(4*acc), 32'h0, 1'b0);
      if (last_acc) acc++;
    end
    chk("t3_accepted", 32'(acc), 32'(RSP_DEPTH));
    chk("t3_req_rdy_low", 32'(bus.req_rdy), 32'd0);
    idle(1'b1);
    chk("t3_req_rdy_back", 32'(bus.req_rdy), 32'd1);
    step(1'b1, CMD_READ, 32'h2000 + 32'(4*RSP_DEPTH), 32'h0, 1'b0);
    chk("t3_extra_acc", 32'(last_acc), 32'd1);
    chk("t3_req_rdy_low2", 32'(bus.req_rdy), 32'd0);

    // 4: pop exactly on the edge where the in-flight read lands
    for (int i = 1; i < READ_LAT; i++) idle(1'b0);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);
    drain("t4", RSP_DEPTH + 1);
    for (int i = 0; i <= RSP_DEPTH; i++)
      if (i < got.size()) chk($sformatf("t4_order%0d", i), got[i], 32'h3000 + 32'(i));

    // 4b: pointer wrap with 3*RSP_DEPTH reads
    got.delete();
    exp_q.delete();
    for (int i = 0; i < 3*RSP_DEPTH; i++) begin
      a = 32'h1000 + 32'(4*$urandom_range(0, 15));
      exp_q.push_back(m_mem[widx(a)]);
      step(1'b1, CMD_READ, a, 32'h0, 1'b1);
    end
    drain("t4_wrap", 3*RSP_DEPTH);
    foreach (exp_q[i])
      if (i < got.size()) chk($sformatf("t4_wrap%0d", i), got[i], exp_q[i]);

    // 5: read-after-write ordering on consecutive cycles
    tq.delete();
    tq.push_back(mk(CMD_WRITE, 32'h40, 32'h11, 32'h0));
    tq.push_back(mk(CMD_READ,  32'h40, 32'h0,  32'h11));
    tq.push_back(mk(CMD_WRITE, 32'h40, 32'h22, 32'h0));
    tq.push_back(mk(CMD_READ,  32'h40, 32'h0,  32'h22));
    run_table("t5");

    // random traffic against the model
    rdy_ok = 1;
    for (int i = 0; i < 400; i++) begin
      a = 32'h1000 + 32'(4*$urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
           1'($urandom_range(0, 9) < 7));
    end
    n = 0;
    while ((m_pipe.size() + m_fifo.size()) > 0 && n < 60) begin idle(1'b1); n++; end
    chk("rand_drained", 32'(m_pipe.size() + m_fifo.size()), 32'd0);

    // 6: reset with 3 reads in the pipe and 2 responses queued
    got.delete();
    for (int i = 0; i < 5; i++) step(1'b1, CMD_READ, 32'h40, 32'h0, 1'b0);
    idle(1'b0);
    rstn = 0;
    #1;
    chk("t6_rsp_en", 32'(bus.rsp_en), 32'd0);
    chk("t6_req_rdy", 32'(bus.req_rdy), 32'd0);
    chk("t6_rsp_data", bus.rsp_data, 32'h0);
    m_pipe.delete();
    m_fifo.delete();
    m_run = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rstn = 1;
    for (int i = 0; i < 10; i++) idle(1'b1);
    chk("t6_no_stale", 32'(got.size()), 32'd0);
    tq.delete();
    tq.push_back(mk(CMD_READ, 32'h40, 32'h0, 32'h22));
    run_table("t6");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
